q3_output_capture: RTL and testbench
====================================

Name: q3_output_capture

Overview:
- Downstream capture stage for the student_circuit_Q3 datapath; data_in connects directly to that circuit's cct_output.
- After a start command, waits a programmable number of settle cycles so that pipeline register latency is flushed.
- Then captures a fixed-length burst of samples into a small FIFO while keeping a running XOR checksum and an accepted-sample count.
- The bench or host drains the FIFO through a registered read port.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2, >= 2
SKIP_CYCLES, 2, samples discarded after start; 0 is legal
CAPTURE_LEN, 8, samples attempted per burst, 1..255

Ports:
clk  in  1  clock; all logic on rising edge
clear_n  in  1  synchronous active-low reset
data_in  in  8  sample stream (from cct_output)
start  in  1  begin burst; honoured only in IDLE or DONE
rd_en  in  1  pop request
rd_data  out  8  popped sample, registered
rd_valid  out  1  rd_data valid, 1-cycle pulse
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  log2(DEPTH)+1  entries held
busy  out  1  state is SKIP or CAPTURE
done  out  1  state is DONE
overflow  out  1  sticky: a sample was dropped because the FIFO was full
sample_count  out  8  samples accepted in the current burst
checksum  out  8  XOR of samples accepted in the current burst

Behaviour:
Reset:
- clear_n=0 at an edge forces state IDLE and clears the FIFO pointers.
- All outputs go to 0, except empty=1. Reset wins over every other input, including mid-burst.
FSM states: IDLE, SKIP, CAPTURE, DONE.
- IDLE, start=1: enter SKIP with skip counter = SKIP_CYCLES. If SKIP_CYCLES=0, enter CAPTURE directly.
- SKIP: data_in is ignored. After exactly SKIP_CYCLES edges in SKIP, enter CAPTURE with the attempt counter = 0.
- CAPTURE: every edge samples data_in as one attempt.
  - Accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Accepted: push, checksum ^= data_in, sample_count += 1.
  - Rejected: overflow set to 1, data discarded.
  - After CAPTURE_LEN attempts, enter DONE on that same edge.
- DONE: holds all values. start=1 begins a new burst (SKIP or CAPTURE, per SKIP_CYCLES). On the start edge, checksum, sample_count and overflow clear to 0. FIFO contents are kept.
- start is ignored in SKIP and CAPTURE.
- Timing: start sampled at edge T0. Samples at edges T0+1 .. T0+SKIP_CYCLES are discarded. Samples at edges T0+SKIP_CYCLES+1 .. T0+SKIP_CYCLES+CAPTURE_LEN are attempted. done=1 after the last attempt edge.
FIFO:
- Circular buffer; pointers wrap modulo DEPTH.
- level, empty and full are updated at the edge of push/pop. full means level==DEPTH.
Read:
- rd_en=1 and not empty at edge T: rd_data <= head entry, rd_valid=1 after edge T (for one cycle), level decrements.
- rd_en while empty: ignored, rd_valid=0, rd_data holds its value.
- Reads are legal in every state.
- Simultaneous push and pop: level is unchanged. When empty, push and rd_en on the same edge give no pop; the data appears on the next read.
sample_count and checksum use 8-bit wrap arithmetic; CAPTURE_LEN<=255 prevents count wrap.

Test Plan:
1. Reset: clear_n=0 for 2 edges with start/rd_en toggling -> empty=1, all other outputs 0, state IDLE.
2. Default params, data_in=0x10+k at edge T0+k, start at T0 -> pushes 0x13..0x1A; done=1 after T0+10; sample_count=8; checksum=0x08; full=1; overflow=0.
3. After case 2, rd_en for 8 consecutive cycles -> rd_data 0x13..0x1A, each with rd_valid one cycle after its rd_en; then empty=1, level=0. A 9th rd_en gives rd_valid=0.
4. CAPTURE_LEN=12, no reads, same stimulus -> 0x13..0x1A stored; 4 samples dropped; overflow=1; sample_count=8; checksum=0x08; done after T0+14.
5. FIFO full in CAPTURE with rd_en held high -> every sample accepted, level stays 8, overflow=0. Then restart from DONE -> checksum, count and overflow clear, FIFO data retained.
6. clear_n=0 at edge T0+5 mid-burst -> IDLE and empty=1 on the next cycle; later start runs a clean burst matching case 2.

Source files
------------

// File: rtl/q3_output_capture.sv
// Capture stage for the student_circuit_Q3 datapath: after a start command it skips
// SKIP_CYCLES samples, then records a CAPTURE_LEN burst into a FIFO with XOR checksum.
module q3_output_capture #(
    parameter int DEPTH       = 8,
    parameter int SKIP_CYCLES = 2,
    parameter int CAPTURE_LEN = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic [7:0]    data_in,
    input  logic          start,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [7:0]    sample_count,
    output logic [7:0]    checksum,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [7:0]  SKIP_INIT = 8'(SKIP_CYCLES);
    localparam logic [7:0]  LAST_ATT  = 8'(CAPTURE_LEN - 1);

    state_t        state_q;
    logic [7:0]    skip_q;
    logic [7:0]    att_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;
    logic          ovf_q;
    logic [7:0]    cnt_q;
    logic [7:0]    ck_q;
    logic [7:0]    mem [DEPTH];

    logic          pop;
    logic          push;

    // A full FIFO still accepts a sample when a pop frees the slot on the same edge.
    always_comb begin
        pop     = rd_en && (level_q != '0);
        push    = (state_q == CAPTURE) && ((level_q != FULL_LVL) || pop);
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            skip_q     <= '0;
            att_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            ck_q       <= '0;
        end else begin
            rd_valid_q <= pop;
            level_q    <= level_d;
            if (pop) begin
                rd_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        cnt_q   <= '0;
                        ck_q    <= '0;
                        ovf_q   <= 1'b0;
                        att_q   <= '0;
                        skip_q  <= SKIP_INIT;
                        state_q <= (SKIP_CYCLES == 0) ? CAPTURE : SKIP;
                    end
                end
                SKIP: begin
                    skip_q <= skip_q - 1'b1;
                    if (skip_q == 8'd1) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (push) begin
                        cnt_q <= cnt_q + 1'b1;
                        ck_q  <= ck_q ^ data_in;
                    end else begin
                        ovf_q <= 1'b1;
                    end
                    att_q <= att_q + 1'b1;
                    if (att_q == LAST_ATT) begin
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign full         = (level_q == FULL_LVL);
    assign busy         = (state_q == SKIP) || (state_q == CAPTURE);
    assign done         = (state_q == DONE);
    assign overflow     = ovf_q;
    assign sample_count = cnt_q;
    assign checksum     = ck_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_q3_output_capture.sv
// Directed bench: instance a uses defaults, instance b uses CAPTURE_LEN=12 for overflow cases.
module tb_q3_output_capture;

    logic       clk;
    logic       clear_n;
    logic [7:0] data_in;
    logic       start_a, start_b;
    logic       rd_a, rd_b;

    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b;
    logic       empty_a, empty_b;
    logic       full_a, full_b;
    logic [3:0] level_a, level_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic       ovf_a, ovf_b;
    logic [7:0] cnt_a, cnt_b;
    logic [7:0] ck_a, ck_b;
    logic [1:0] st_a, st_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_ck;
    logic [7:0] exp_rd;

    q3_output_capture u_dut_a (
        .clk(clk), .clear_n(clear_n), .data_in(data_in), .start(start_a), .rd_en(rd_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .empty(empty_a), .full(full_a),
        .level(level_a), .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .sample_count(cnt_a), .checksum(ck_a), .dbg_state(st_a)
    );

    q3_output_capture #(.CAPTURE_LEN(12)) u_dut_b (
        .clk(clk), .clear_n(clear_n), .data_in(data_in), .start(start_b), .rd_en(rd_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b), .full(full_b),
        .level(level_b), .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .sample_count(cnt_b), .checksum(ck_b), .dbg_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear_n = 1'b0; data_in = 8'h00;
        start_a = 1'b0; start_b = 1'b0; rd_a = 1'b0; rd_b = 1'b0;

        // reset held for two edges while start/rd_en toggle
        @(negedge clk);
        start_a = 1'b1; start_b = 1'b1; rd_a = 1'b1; rd_b = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0; rd_a = 1'b0; rd_b = 1'b0;
        step();
        chk("rst_empty", 16'(empty_a), 16'h1);
        chk("rst_state", 16'(st_a), 16'h0);
        chk("rst_level", 16'(level_a), 16'h0);
        chk("rst_full_busy_done", {13'h0, full_a, busy_a, done_a}, 16'h0);
        chk("rst_ovf_valid", {14'h0, ovf_a, rd_valid_a}, 16'h0);
        chk("rst_cnt_ck", {cnt_a, ck_a}, 16'h0);
        chk("rst_rd_data", 16'(rd_data_a), 16'h0);
        chk("rst_b_empty_state", {13'h0, empty_b, st_b}, 16'h4);
        clear_n = 1'b1;

        // burst on both instances: data 0x10+k at edge T0+k
        start_a = 1'b1; start_b = 1'b1; data_in = 8'h10;
        step();
        start_a = 1'b0; start_b = 1'b0;
        chk("a_busy_skip", {14'h0, busy_a, done_a}, 16'h2);
        for (int k = 1; k <= 14; k++) begin
            data_in = 8'h10 + 8'(k);
            step();
            if (k == 2)  chk("a_enter_capture", {st_a, level_a}, {2'd2, 4'd0});
            if (k == 9)  chk("a_not_done_t9", {14'h0, busy_a, done_a}, 16'h2);
            if (k == 10) begin
                chk("a_done_t10", {14'h0, busy_a, done_a}, 16'h1);
                chk("a_count", 16'(cnt_a), 16'h08);
                chk("a_checksum", 16'(ck_a), 16'h08);
                chk("a_full_ovf", {12'h0, level_a[3:0]} | {full_a, ovf_a, 14'h0}, 16'h8008);
                chk("b_no_ovf_t10", 16'(ovf_b), 16'h0);
            end
            if (k == 11) chk("b_ovf_t11", 16'(ovf_b), 16'h1);
            if (k == 13) chk("b_not_done_t13", 16'(done_b), 16'h0);
        end
        chk("b_done_t14", 16'(done_b), 16'h1);
        chk("b_count", 16'(cnt_b), 16'h08);
        chk("b_checksum", 16'(ck_b), 16'h08);
        chk("b_full_ovf", {14'h0, full_b, ovf_b}, 16'h3);
        chk("a_hold_count", {cnt_a, ck_a}, 16'h0808);

        // drain instance a
        for (int i = 0; i < 8; i++) begin
            rd_a = 1'b1;
            step();
            exp_rd = 8'h13 + 8'(i);
            chk("a_rd_valid", 16'(rd_valid_a), 16'h1);
            chk("a_rd_data", 16'(rd_data_a), 16'(exp_rd));
        end
        chk("a_drained", {11'h0, empty_a, level_a}, 16'h10);
        step();
        chk("a_rd_empty_valid", 16'(rd_valid_a), 16'h0);
        chk("a_rd_empty_hold", 16'(rd_data_a), 16'h1A);
        rd_a = 1'b0;

        // restart b from DONE while full, pop on every capture edge
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("b_restart_clear", {cnt_b, ck_b}, 16'h0);
        chk("b_restart_ovf_busy", {14'h0, ovf_b, busy_b}, 16'h1);
        chk("b_restart_level", 16'(level_b), 16'h8);
        step();
        step();
        chk("b_skip_level", 16'(level_b), 16'h8);
        exp_ck = 8'h00;
        for (int j = 0; j < 12; j++) begin
            data_in = 8'h40 + 8'(3 * j);
            exp_ck  = exp_ck ^ data_in;
            rd_b = 1'b1;
            step();
            exp_rd = (j < 8) ? 8'h13 + 8'(j) : 8'h40 + 8'(3 * (j - 8));
            chk("b_pass_level", 16'(level_b), 16'h8);
            chk("b_pass_rd", {7'h0, rd_valid_b, rd_data_b}, {8'h01, exp_rd});
        end
        rd_b = 1'b0;
        chk("b_pass_done", 16'(done_b), 16'h1);
        chk("b_pass_count", 16'(cnt_b), 16'h0C);
        chk("b_pass_checksum", 16'(ck_b), 16'(exp_ck));
        chk("b_pass_ovf", 16'(ovf_b), 16'h0);

        // reset lands at edge T0+5 of a burst on instance a
        start_a = 1'b1; data_in = 8'h10;
        step();
        start_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            data_in = 8'h10 + 8'(k);
            step();
        end
        chk("a_mid_count", 16'(cnt_a), 16'h02);
        clear_n = 1'b0; data_in = 8'h15;
        step();
        clear_n = 1'b1;
        chk("a_midrst_state", {13'h0, empty_a, st_a}, 16'h4);
        chk("a_midrst_regs", {cnt_a, ck_a}, 16'h0);
        chk("a_midrst_busy_level", {11'h0, busy_a, level_a}, 16'h0);
        chk("b_midrst_empty", 16'(empty_b), 16'h1);

        // clean burst after the mid-burst reset
        start_a = 1'b1; data_in = 8'h10;
        step();
        start_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            data_in = 8'h10 + 8'(k);
            step();
        end
        chk("a_clean_done", 16'(done_a), 16'h1);
        chk("a_clean_cnt_ck", {cnt_a, ck_a}, 16'h0808);
        chk("a_clean_full_ovf", {14'h0, full_a, ovf_a}, 16'h2);
        rd_a = 1'b1;
        step();
        rd_a = 1'b0;
        chk("a_clean_first_rd", {7'h0, rd_valid_a, rd_data_a}, 16'h0113);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
